// File: rtl/mask_deserializer_if.sv
// mask_deserializer_if: word input, row output and control signals of the mask deserializer.
interface mask_deserializer_if #(
    parameter int IP_CHANNEL_WIDTH = 1080,
    parameter int OP_CHANNEL_WIDTH = 20
);
    logic [1:0]                  imageResolution;
    logic                        start;
    logic                        abort;
    logic [OP_CHANNEL_WIDTH-1:0] din;
    logic                        din_valid;
    logic                        din_ready;
    logic [IP_CHANNEL_WIDTH-1:0] row_mask;
    logic                        row_valid;
    logic                        row_ready;
    logic                        busy;
    logic                        res_err;
    modport slave (
        input  imageResolution, start, abort, din, din_valid, row_ready,
        output din_ready, row_mask, row_valid, busy, res_err
    );
    modport master (
        output imageResolution, start, abort, din, din_valid, row_ready,
        input  din_ready, row_mask, row_valid, busy, res_err
    );
endinterface

// File: rtl/mask_deserializer.sv
// mask_deserializer: rebuilds a full-width row mask from interleaved narrow words and hands it off over valid/ready.
module mask_deserializer #(
    parameter int IP_CHANNEL_WIDTH = 1080,
    parameter int OP_CHANNEL_WIDTH = 20,
    parameter int STEP_SEL0 = 16,
    parameter int STEP_SEL1 = 32,
    parameter int STEP_SEL2 = 54
) (
    input logic clk,
    input logic rst,
    mask_deserializer_if.slave bus
);
    localparam int AW = $clog2(IP_CHANNEL_WIDTH);
    typedef enum logic [1:0] {IDLE, COLLECT, HOLD} state_t;
    state_t state_q, state_d;
    logic [IP_CHANNEL_WIDTH-1:0] row_mask_q, row_mask_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] step_q, step_d;
    logic res_err_q, res_err_d;
    logic [AW-1:0] idx;
    always_comb begin
        state_d    = state_q;
        row_mask_d = row_mask_q;
        cnt_d      = cnt_q;
        step_d     = step_q;
        res_err_d  = 1'b0;
        idx        = '0;
        unique case (state_q)
            IDLE: if (bus.start) begin
                if (bus.imageResolution == 2'b11) res_err_d = 1'b1;
                else begin
                    step_d = bus.imageResolution == 2'b00 ? 8'(STEP_SEL0) :
                             bus.imageResolution == 2'b01 ? 8'(STEP_SEL1) : 8'(STEP_SEL2);
                    row_mask_d = '0;
                    cnt_d      = '0;
                    state_d    = COLLECT;
                end
            end
            COLLECT: if (bus.abort) begin
                state_d = IDLE;
                cnt_d   = '0;
            end else if (bus.din_valid) begin
                // word k bit i lands on pixel i*step+k, undoing the serializer's tap pattern
                for (int i = 0; i < OP_CHANNEL_WIDTH; i++) begin
                    idx = AW'(i) * AW'(step_q) + AW'(cnt_q);
                    if (idx < AW'(IP_CHANNEL_WIDTH)) row_mask_d[idx] = bus.din[i];
                end
                cnt_d = cnt_q + 8'd1;
                if (cnt_q == step_q - 8'd1) state_d = HOLD;
            end
            HOLD: if (bus.abort) begin
                state_d = IDLE;
                cnt_d   = '0;
            end else if (bus.row_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            row_mask_q <= '0;
            cnt_q      <= '0;
            step_q     <= '0;
            res_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            row_mask_q <= row_mask_d;
            cnt_q      <= cnt_d;
            step_q     <= step_d;
            res_err_q  <= res_err_d;
        end
    end
    assign bus.din_ready = state_q == COLLECT;
    assign bus.row_valid = state_q == HOLD;
    assign bus.busy      = state_q != IDLE;
    assign bus.res_err   = res_err_q;
    assign bus.row_mask  = row_mask_q;
endmodule

// File: tb/tb_mask_deserializer.sv
// tb_mask_deserializer: directed vectors with hand-computed expected rows for the mask deserializer.
module tb_mask_deserializer;
    localparam int IW = 1080;
    localparam int OW = 20;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int vec_cnt = 0;
    int err_cnt = 0;
    logic [OW-1:0] words [64];
    logic [IW-1:0] exp_mask;
    int lat, nacc;
    mask_deserializer_if #(.IP_CHANNEL_WIDTH(IW), .OP_CHANNEL_WIDTH(OW)) bus ();
    mask_deserializer dut (.clk(clk), .rst(rst), .bus(bus.slave));
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [IW-1:0] got, input logic [IW-1:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic run_row(input logic [1:0] res, input bit toggle, output int l, output int k);
        bit phase = 1'b0;
        bit acc;
        bus.imageResolution = res;
        bus.start = 1'b1;
        tick;
        bus.start = 1'b0;
        l = 1;
        k = 0;
        while (!bus.row_valid && l < 400) begin
            bus.din_valid = toggle ? phase : 1'b1;
            bus.din = k < 64 ? words[k] : '0;
            acc = bus.din_valid && bus.din_ready;
            tick;
            l++;
            if (acc) k++;
            phase = !phase;
        end
        bus.din_valid = 1'b0;
    endtask
    initial begin
        bus.imageResolution = 2'b00;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.din = '0;
        bus.din_valid = 1'b0;
        bus.row_ready = 1'b1;
        tick;
        tick;
        rst = 1'b0;
        chk("rst_din_ready", IW'(bus.din_ready), '0);
        chk("rst_row_valid", IW'(bus.row_valid), '0);
        chk("rst_busy", IW'(bus.busy), '0);
        chk("rst_res_err", IW'(bus.res_err), '0);
        chk("rst_row_mask", bus.row_mask, '0);
        // 1080 round trip: only pixel 1079 set
        foreach (words[j]) words[j] = '0;
        words[53] = 20'h80000;
        run_row(2'b10, 1'b0, lat, nacc);
        chk("r1080_latency", IW'(lat), IW'(55));
        chk("r1080_words", IW'(nacc), IW'(54));
        exp_mask = '0;
        exp_mask[1079] = 1'b1;
        chk("r1080_mask", bus.row_mask, exp_mask);
        tick;
        chk("r1080_release", IW'(bus.row_valid), '0);
        chk("r1080_idle", IW'(bus.busy), '0);
        chk("r1080_mask_kept", bus.row_mask, exp_mask);
        // 320 mode all ones
        foreach (words[j]) words[j] = 20'hFFFFF;
        run_row(2'b00, 1'b0, lat, nacc);
        chk("r320_latency", IW'(lat), IW'(17));
        exp_mask = '0;
        for (int i = 0; i < 320; i++) exp_mask[i] = 1'b1;
        chk("r320_mask", bus.row_mask, exp_mask);
        tick;
        // 640 with input gaps and output backpressure
        foreach (words[j]) words[j] = '0;
        words[5] = 20'h00008;
        bus.row_ready = 1'b0;
        run_row(2'b01, 1'b1, lat, nacc);
        chk("r640_words", IW'(nacc), IW'(32));
        chk("r640_valid", IW'(bus.row_valid), IW'(1));
        exp_mask = '0;
        exp_mask[101] = 1'b1;
        chk("r640_bit101", IW'(bus.row_mask[101]), IW'(1));
        chk("r640_mask", bus.row_mask, exp_mask);
        for (int c = 0; c < 10; c++) begin
            bus.din_valid = 1'b1;
            bus.din = 20'hFFFFF;
            tick;
            chk("hold_valid", IW'(bus.row_valid), IW'(1));
            chk("hold_din_ready", IW'(bus.din_ready), '0);
            chk("hold_mask", bus.row_mask, exp_mask);
        end
        bus.din_valid = 1'b0;
        bus.row_ready = 1'b1;
        tick;
        chk("hold_release_valid", IW'(bus.row_valid), '0);
        chk("hold_release_busy", IW'(bus.busy), '0);
        // abort beats the final word
        foreach (words[j]) words[j] = 20'hFFFFF;
        bus.imageResolution = 2'b10;
        bus.start = 1'b1;
        tick;
        bus.start = 1'b0;
        bus.din_valid = 1'b1;
        bus.din = 20'hFFFFF;
        for (int c = 0; c < 53; c++) tick;
        chk("abort_pre_busy", IW'(bus.busy), IW'(1));
        chk("abort_pre_valid", IW'(bus.row_valid), '0);
        bus.abort = 1'b1;
        tick;
        bus.abort = 1'b0;
        bus.din_valid = 1'b0;
        chk("abort_valid", IW'(bus.row_valid), '0);
        chk("abort_busy", IW'(bus.busy), '0);
        chk("abort_din_ready", IW'(bus.din_ready), '0);
        tick;
        chk("abort_no_late_valid", IW'(bus.row_valid), '0);
        // reserved resolution
        bus.imageResolution = 2'b11;
        bus.start = 1'b1;
        tick;
        bus.start = 1'b0;
        chk("res_err_pulse", IW'(bus.res_err), IW'(1));
        chk("res_err_idle", IW'(bus.busy), '0);
        tick;
        chk("res_err_drop", IW'(bus.res_err), '0);
        chk("res_err_still_idle", IW'(bus.busy), '0);
        // reset mid-collect, then a clean full row
        bus.imageResolution = 2'b10;
        bus.start = 1'b1;
        tick;
        bus.start = 1'b0;
        chk("mid_din_ready", IW'(bus.din_ready), IW'(1));
        bus.din_valid = 1'b1;
        bus.din = 20'hFFFFF;
        for (int c = 0; c < 20; c++) tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        bus.din_valid = 1'b0;
        chk("mid_rst_din_ready", IW'(bus.din_ready), '0);
        chk("mid_rst_busy", IW'(bus.busy), '0);
        chk("mid_rst_valid", IW'(bus.row_valid), '0);
        chk("mid_rst_mask", bus.row_mask, '0);
        run_row(2'b10, 1'b0, lat, nacc);
        chk("post_rst_latency", IW'(lat), IW'(55));
        chk("post_rst_mask", bus.row_mask, {IW{1'b1}});
        tick;
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
